// File: rtl/gb_int_pkg.sv
// Shared constants, source enumeration and vector helper for the DMG interrupt controller.
package gb_int_pkg;

  localparam int N_SRC = 5;
  localparam int IDX_W = 3;

  localparam logic [15:0] ADDR_IF  = 16'hFF0F;
  localparam logic [15:0] ADDR_IE  = 16'hFFFF;
  localparam logic [15:0] VEC_BASE = 16'h0040;

  typedef enum logic [IDX_W-1:0] {
    INT_VBLANK = 3'd0,
    INT_STAT   = 3'd1,
    INT_TIMER  = 3'd2,
    INT_SERIAL = 3'd3,
    INT_JOYPAD = 3'd4
  } int_src_e;

  // Each source owns an 8-byte slot above VEC_BASE.
  function automatic logic [15:0] vector_of(input logic [IDX_W-1:0] idx);
    return VEC_BASE + {10'd0, idx, 3'b000};
  endfunction

endpackage

// File: rtl/gb_interrupt_ctrl_if.sv
// CPU-side memory bus as seen by the interrupt controller: address, write data/strobe, read data.
interface gb_interrupt_ctrl_if;
  logic [15:0] addr_i;
  logic [7:0]  data_i;
  logic        wr_en_i;
  logic [7:0]  data_o;
  logic        rd_hit_o;

  modport master (output addr_i, output data_i, output wr_en_i,
                  input data_o, input rd_hit_o);
  modport slave  (input addr_i, input data_i, input wr_en_i,
                  output data_o, output rd_hit_o);
endinterface

// File: rtl/gb_int_prio_enc.sv
// Fixed-priority encoder: lowest set request bit wins; idx is 0 when nothing is requested.
module gb_int_prio_enc #(
  parameter int WIDTH = 5,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] req_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the top down so the lowest set bit is the last one to overwrite idx_o.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      if (req_i[k]) idx_o = IDX_W'(k);
    end
  end

endmodule

// File: rtl/gb_interrupt_ctrl.sv
// DMG interrupt controller: IF/IE registers, source edge detection, bus access and priority resolution.
module gb_interrupt_ctrl
  import gb_int_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  gb_interrupt_ctrl_if.slave    bus,
  input  logic [N_SRC-1:0]      irq_src_i,
  input  logic                  int_ack_i,
  input  logic [IDX_W-1:0]      int_ack_idx_i,
  output logic [7:0]            reg_IF,
  output logic [7:0]            reg_IE,
  output logic                  irq_pending_o,
  output logic [IDX_W-1:0]      irq_idx_o,
  output logic [15:0]           irq_vector_o
);

  logic [N_SRC-1:0] if_q, if_d;
  logic [7:0]       ie_q, ie_d;
  logic [N_SRC-1:0] src_q;

  logic             wrIf;
  logic             wrIe;
  logic [N_SRC-1:0] edgeMask;
  logic [N_SRC-1:0] ackMask;

  assign wrIf     = bus.wr_en_i && (bus.addr_i == ADDR_IF);
  assign wrIe     = bus.wr_en_i && (bus.addr_i == ADDR_IE);
  assign edgeMask = irq_src_i & ~src_q;

  // Ack clears one IF bit; out-of-range indices match no bit and so change nothing.
  always_comb begin
    ackMask = '0;
    for (int k = 0; k < N_SRC; k++) begin
      ackMask[k] = int_ack_i && (int_ack_idx_i == IDX_W'(k));
    end
  end

  // Write replaces IF, ack then clears, and a fresh edge is ORed last so it is never lost.
  always_comb begin
    if_d = ((wrIf ? bus.data_i[N_SRC-1:0] : if_q) & ~ackMask) | edgeMask;
    ie_d = wrIe ? bus.data_i : ie_q;
  end

  // Register update; reset samples the sources so a level held through reset raises nothing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if_q  <= '0;
      ie_q  <= '0;
      src_q <= irq_src_i;
    end else begin
      if_q  <= if_d;
      ie_q  <= ie_d;
      src_q <= irq_src_i;
    end
  end

  // Register read port; a write cycle never reports a read hit.
  always_comb begin
    bus.data_o   = 8'h00;
    bus.rd_hit_o = 1'b0;
    if (!bus.wr_en_i) begin
      if (bus.addr_i == ADDR_IF) begin
        bus.data_o   = {3'b111, if_q};
        bus.rd_hit_o = 1'b1;
      end else if (bus.addr_i == ADDR_IE) begin
        bus.data_o   = ie_q;
        bus.rd_hit_o = 1'b1;
      end
    end
  end

  assign reg_IF = {3'b111, if_q};
  assign reg_IE = ie_q;

  gb_int_prio_enc #(
    .WIDTH (N_SRC),
    .IDX_W (IDX_W)
  ) u_prio (
    .req_i   (if_q & ie_q[N_SRC-1:0]),
    .valid_o (irq_pending_o),
    .idx_o   (irq_idx_o)
  );

  assign irq_vector_o = vector_of(irq_idx_o);

endmodule

// File: tb/tb_gb_interrupt_ctrl.sv
// Self-checking bench for gb_interrupt_ctrl: vector table with a post-edge scoreboard plus reset sequences.
module tb_gb_interrupt_ctrl;
  import gb_int_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  irqSrc;
  logic        intAck;
  logic [2:0]  intAckIdx;
  logic [7:0]  regIF;
  logic [7:0]  regIE;
  logic        irqPending;
  logic [2:0]  irqIdx;
  logic [15:0] irqVector;

  int checks   = 0;
  int failures = 0;

  gb_interrupt_ctrl_if busIf ();

  gb_interrupt_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (busIf),
    .irq_src_i     (irqSrc),
    .int_ack_i     (intAck),
    .int_ack_idx_i (intAckIdx),
    .reg_IF        (regIF),
    .reg_IE        (regIE),
    .irq_pending_o (irqPending),
    .irq_idx_o     (irqIdx),
    .irq_vector_o  (irqVector)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  src;
    logic        ack;
    logic [2:0]  ackIdx;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        expHit;
    logic [7:0]  expData;
    logic [7:0]  expIF;
    logic [7:0]  expIE;
    logic        expPend;
    logic [2:0]  expIdx;
    logic [15:0] expVec;
  } vec_t;

  typedef struct {
    logic [7:0]  expIF;
    logic [7:0]  expIE;
    logic        expPend;
    logic [2:0]  expIdx;
    logic [15:0] expVec;
    int          row;
  } exp_t;

  localparam int N_VEC = 24;
  vec_t vecs[N_VEC];
  exp_t sb[$];

  function automatic vec_t mk(input logic [4:0] src, input logic ack, input logic [2:0] ackIdx,
                              input logic wr, input logic [15:0] addr, input logic [7:0] wdata,
                              input logic expHit, input logic [7:0] expData,
                              input logic [7:0] expIF, input logic [7:0] expIE,
                              input logic expPend, input logic [2:0] expIdx,
                              input logic [15:0] expVec);
    vec_t v;
    v.src = src; v.ack = ack; v.ackIdx = ackIdx; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.expHit = expHit; v.expData = expData; v.expIF = expIF; v.expIE = expIE;
    v.expPend = expPend; v.expIdx = expIdx; v.expVec = expVec;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Checks every registered output against one expected record.
  task automatic checkRegs(input string tag, input logic [7:0] eIF, input logic [7:0] eIE,
                           input logic ePend, input logic [2:0] eIdx, input logic [15:0] eVec);
    checkOutput({tag, " reg_IF"}, {8'h00, regIF}, {8'h00, eIF});
    checkOutput({tag, " reg_IE"}, {8'h00, regIE}, {8'h00, eIE});
    checkOutput({tag, " pending"}, {15'h0, irqPending}, {15'h0, ePend});
    checkOutput({tag, " idx"}, {13'h0, irqIdx}, {13'h0, eIdx});
    checkOutput({tag, " vector"}, irqVector, eVec);
  endtask

  task automatic setIdle();
    intAck        = 1'b0;
    intAckIdx     = 3'd0;
    busIf.wr_en_i = 1'b0;
    busIf.addr_i  = 16'h0000;
    busIf.data_i  = 8'h00;
  endtask

  // Drives one row just after a posedge, checks the combinational read port, queues the
  // post-edge expectation, then clocks and compares against the popped record.
  task automatic applyStimulus(input int row, input vec_t v);
    exp_t e;
    exp_t got;
    irqSrc        = v.src;
    intAck        = v.ack;
    intAckIdx     = v.ackIdx;
    busIf.wr_en_i = v.wr;
    busIf.addr_i  = v.addr;
    busIf.data_i  = v.wdata;
    #1;
    checkOutput($sformatf("row%0d rd_hit", row), {15'h0, busIf.rd_hit_o}, {15'h0, v.expHit});
    checkOutput($sformatf("row%0d data_o", row), {8'h00, busIf.data_o}, {8'h00, v.expData});
    e.expIF = v.expIF; e.expIE = v.expIE; e.expPend = v.expPend;
    e.expIdx = v.expIdx; e.expVec = v.expVec; e.row = row;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL row%0d scoreboard: got empty queue, expected one entry", row);
    end else begin
      got = sb.pop_front();
      checkRegs($sformatf("row%0d", got.row), got.expIF, got.expIE, got.expPend, got.expIdx,
                got.expVec);
    end
  endtask

  initial begin
    // Rows start with if=0, ie=0 and VBlank held high through reset.
    vecs[0]  = mk(5'b00000, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 8'hE0, 8'h00, 0, 0, 16'h0040);
    vecs[1]  = mk(5'b00001, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 8'hE1, 8'h00, 0, 0, 16'h0040);
    vecs[2]  = mk(5'b00001, 0, 0, 1, 16'hFFFF, 8'h1F, 0, 8'h00, 8'hE1, 8'h1F, 1, 0, 16'h0040);
    vecs[3]  = mk(5'b00001, 0, 0, 1, 16'hFF0F, 8'h00, 0, 8'h00, 8'hE0, 8'h1F, 0, 0, 16'h0040);
    vecs[4]  = mk(5'b01100, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 8'hEC, 8'h1F, 1, 2, 16'h0050);
    vecs[5]  = mk(5'b00000, 1, 2, 0, 16'h0000, 8'h00, 0, 8'h00, 8'hE8, 8'h1F, 1, 3, 16'h0058);
    vecs[6]  = mk(5'b00000, 1, 3, 0, 16'h0000, 8'h00, 0, 8'h00, 8'hE0, 8'h1F, 0, 0, 16'h0040);
    vecs[7]  = mk(5'b00001, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 8'hE1, 8'h1F, 1, 0, 16'h0040);
    vecs[8]  = mk(5'b00000, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 8'hE1, 8'h1F, 1, 0, 16'h0040);
    vecs[9]  = mk(5'b00001, 1, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 8'hE1, 8'h1F, 1, 0, 16'h0040);
    vecs[10] = mk(5'b00011, 0, 0, 1, 16'hFF0F, 8'h00, 0, 8'h00, 8'hE2, 8'h1F, 1, 1, 16'h0048);
    vecs[11] = mk(5'b00000, 0, 0, 1, 16'hFF0F, 8'h04, 0, 8'h00, 8'hE4, 8'h1F, 1, 2, 16'h0050);
    vecs[12] = mk(5'b00000, 0, 0, 0, 16'hFF0F, 8'h00, 1, 8'hE4, 8'hE4, 8'h1F, 1, 2, 16'h0050);
    vecs[13] = mk(5'b00000, 0, 0, 1, 16'hFFFF, 8'hA5, 0, 8'h00, 8'hE4, 8'hA5, 1, 2, 16'h0050);
    vecs[14] = mk(5'b00000, 0, 0, 0, 16'hFFFF, 8'h00, 1, 8'hA5, 8'hE4, 8'hA5, 1, 2, 16'h0050);
    vecs[15] = mk(5'b00000, 0, 0, 0, 16'hC000, 8'h00, 0, 8'h00, 8'hE4, 8'hA5, 1, 2, 16'h0050);
    vecs[16] = mk(5'b00000, 1, 6, 0, 16'h0000, 8'h00, 0, 8'h00, 8'hE4, 8'hA5, 1, 2, 16'h0050);
    vecs[17] = mk(5'b00000, 0, 0, 1, 16'hFF0F, 8'hFF, 0, 8'h00, 8'hFF, 8'hA5, 1, 0, 16'h0040);
    vecs[18] = mk(5'b00000, 0, 0, 1, 16'hFFFF, 8'h1F, 0, 8'h00, 8'hFF, 8'h1F, 1, 0, 16'h0040);
    vecs[19] = mk(5'b00000, 1, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 8'hFE, 8'h1F, 1, 1, 16'h0048);
    vecs[20] = mk(5'b00000, 1, 1, 0, 16'h0000, 8'h00, 0, 8'h00, 8'hFC, 8'h1F, 1, 2, 16'h0050);
    vecs[21] = mk(5'b00000, 1, 2, 0, 16'h0000, 8'h00, 0, 8'h00, 8'hF8, 8'h1F, 1, 3, 16'h0058);
    vecs[22] = mk(5'b00000, 1, 3, 0, 16'h0000, 8'h00, 0, 8'h00, 8'hF0, 8'h1F, 1, 4, 16'h0060);
    vecs[23] = mk(5'b00000, 0, 0, 1, 16'hFF0F, 8'h1F, 0, 8'h00, 8'hFF, 8'h1F, 1, 0, 16'h0040);

    // Reset with VBlank held high: nothing latched during or right after reset.
    reset  = 1'b0;
    irqSrc = 5'b00001;
    setIdle();
    repeat (2) @(posedge clk);
    #1;
    checkRegs("reset", 8'hE0, 8'h00, 1'b0, 3'd0, 16'h0040);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkRegs("held-src", 8'hE0, 8'h00, 1'b0, 3'd0, 16'h0040);

    for (int i = 0; i < N_VEC; i++) begin
      applyStimulus(i, vecs[i]);
    end
    checkOutput("scoreboard drained", 16'(sb.size()), 16'd0);

    // Mid-run reset with IF=1F, IE=1F and a pending ack: everything returns to reset values.
    setIdle();
    irqSrc    = 5'b00100;
    intAck    = 1'b1;
    intAckIdx = 3'd4;
    reset     = 1'b0;
    @(posedge clk);
    #1;
    checkRegs("mid-reset", 8'hE0, 8'h00, 1'b0, 3'd0, 16'h0040);
    intAck       = 1'b0;
    busIf.addr_i = 16'hFFFF;
    #1;
    checkOutput("mid-reset read IE", {7'h0, busIf.rd_hit_o, busIf.data_o}, 16'h0100);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkRegs("post-reset held timer", 8'hE0, 8'h00, 1'b0, 3'd0, 16'h0040);

    // Timer drops and re-rises: IF bit 2 appears one edge later.
    irqSrc = 5'b00000;
    @(posedge clk);
    #1;
    irqSrc = 5'b00100;
    @(posedge clk);
    #1;
    checkOutput("timer re-raise IF", {8'h00, regIF}, 16'h00E4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
